// File: rtl/motor_pkg.sv
// Shared types and helpers for the two-channel motor drive sequencer.
package motor_pkg;

    localparam int DUTY_W = 10;

    // Motion command encodings carried on cmd_op.
    typedef enum logic [2:0] {
        OP_STOP    = 3'd0,
        OP_FWD     = 3'd1,
        OP_REV     = 3'd2,
        OP_SPIN_L  = 3'd3,
        OP_SPIN_R  = 3'd4,
        OP_PIVOT_L = 3'd5,
        OP_PIVOT_R = 3'd6,
        OP_RSVD    = 3'd7
    } cmd_op_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_BRAKE = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;

    // Per-motor target: direction (1 = forward) and duty.
    typedef struct packed {
        logic              dir;
        logic [DUTY_W-1:0] duty;
    } motor_tgt_t;

    function automatic motor_tgt_t mk_tgt(input logic dir, input logic [DUTY_W-1:0] duty);
        motor_tgt_t t;
        t.dir  = dir;
        t.duty = duty;
        return t;
    endfunction

    // Limit a commanded speed to the PWM period count.
    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] v, input int duty_max);
        int vi;
        vi = {{(32-DUTY_W){1'b0}}, v};
        if (vi > duty_max) begin
            vi = duty_max;
        end
        return DUTY_W'(vi);
    endfunction

    // One slew step: snap to the goal when within one step, else move one step toward it.
    function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                      input logic [DUTY_W-1:0] goal,
                                                      input int step,
                                                      input int duty_max);
        int c;
        int g;
        int r;
        c = {{(32-DUTY_W){1'b0}}, cur};
        g = {{(32-DUTY_W){1'b0}}, goal};
        if (g > c) begin
            r = ((g - c) <= step) ? g : c + step;
        end else begin
            r = ((c - g) <= step) ? g : c - step;
        end
        if (r > duty_max) begin
            r = duty_max;
        end
        if (r < 0) begin
            r = 0;
        end
        return DUTY_W'(r);
    endfunction

endpackage

// File: rtl/motor_ramp_channel.sv
// One motor channel: duty/direction state plus target registers, slewed on ramp ticks.
module motor_ramp_channel
    import motor_pkg::*;
#(
    parameter int STEP     = 10,
    parameter int DUTY_MAX = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              estop,
    input  logic              step_en,
    input  logic              brake,
    input  logic              load,
    input  motor_tgt_t        load_tgt,
    input  logic              dir_apply,
    output logic [DUTY_W-1:0] duty,
    output logic              dir,
    output logic              reversing,
    output logic              at_target,
    output logic              at_zero
);

    logic [DUTY_W-1:0] duty_reg;
    logic              dir_reg;
    logic [DUTY_W-1:0] tgt_duty_reg;
    logic              tgt_dir_reg;
    logic [DUTY_W-1:0] goal;

    assign reversing = (tgt_dir_reg != dir_reg);
    assign at_target = (duty_reg == tgt_duty_reg);
    assign at_zero   = (duty_reg == '0);

    // A reversing motor must coast to zero while braking, whatever its final target.
    assign goal = (brake && reversing) ? '0 : tgt_duty_reg;

    // Duty slews on ticks; targets load on accept; direction flips only when told to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_reg     <= '0;
            dir_reg      <= 1'b1;
            tgt_duty_reg <= '0;
            tgt_dir_reg  <= 1'b1;
        end else if (estop) begin
            duty_reg     <= '0;
            tgt_duty_reg <= '0;
            tgt_dir_reg  <= dir_reg;
        end else begin
            if (step_en) begin
                duty_reg <= step_toward(duty_reg, goal, STEP, DUTY_MAX);
            end
            if (load) begin
                tgt_duty_reg <= load_tgt.duty;
                tgt_dir_reg  <= load_tgt.dir;
            end
            if (dir_apply) begin
                dir_reg <= tgt_dir_reg;
            end
        end
    end

    assign duty = duty_reg;
    assign dir  = dir_reg;

endmodule

// File: rtl/motor_drive_ctrl.sv
// Drive-command sequencer: op decode, ramp prescaler, brake/dead-time FSM for two motors.
module motor_drive_ctrl
    import motor_pkg::*;
#(
    parameter int RAMP_DIV   = 1000,
    parameter int STEP       = 10,
    parameter int DUTY_MAX   = 1000,
    parameter int DEAD_TICKS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DUTY_W-1:0] cmd_speed,
    input  logic              estop,
    output logic [DUTY_W-1:0] duty_l,
    output logic [DUTY_W-1:0] duty_r,
    output logic              dir_l,
    output logic              dir_r,
    output logic              busy
);

    localparam int PW  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DCW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS + 1) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(RAMP_DIV - 1);
    localparam logic [DCW-1:0] DEAD_LAST  = DCW'(DEAD_TICKS - 1);

    // Index 0 is the left motor, index 1 the right motor.
    logic [PW-1:0]                 presc_reg;
    logic                          tick;
    state_t                        state_reg;
    logic                          cmd_ready_reg;
    logic                          busy_reg;
    logic [DCW-1:0]                dead_cnt_reg;

    logic                          accept;
    logic                          cmd_load;
    logic [DUTY_W-1:0]             speed_clamped;
    motor_tgt_t [1:0]              new_tgt;
    logic [1:0]                    rev_new;
    logic                          rev_any_new;
    logic                          brake_done;
    logic                          dead_done;

    logic                          step_en;
    logic                          brake;
    logic                          dir_apply;
    logic [1:0][DUTY_W-1:0]        duty_w;
    logic [1:0]                    dir_w;
    logic [1:0]                    rev_w;
    logic [1:0]                    at_tgt_w;
    logic [1:0]                    at_zero_w;

    // Free-running ramp prescaler; commands never restart it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
        end else if (presc_reg == PRESC_LAST) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    assign tick = (presc_reg == PRESC_LAST);

    // Estop blocks the handshake even in the cycle before cmd_ready drops.
    assign accept        = cmd_valid && cmd_ready_reg && !estop;
    assign cmd_load      = accept && (cmd_op_t'(cmd_op) != OP_RSVD);
    assign speed_clamped = clamp_duty(cmd_speed, DUTY_MAX);

    // Op decode into per-motor targets; "unchanged" direction means keep the present one.
    always_comb begin
        new_tgt[0] = mk_tgt(dir_w[0], '0);
        new_tgt[1] = mk_tgt(dir_w[1], '0);
        case (cmd_op_t'(cmd_op))
            OP_FWD: begin
                new_tgt[0] = mk_tgt(1'b1, speed_clamped);
                new_tgt[1] = mk_tgt(1'b1, speed_clamped);
            end
            OP_REV: begin
                new_tgt[0] = mk_tgt(1'b0, speed_clamped);
                new_tgt[1] = mk_tgt(1'b0, speed_clamped);
            end
            OP_SPIN_L: begin
                new_tgt[0] = mk_tgt(1'b0, speed_clamped);
                new_tgt[1] = mk_tgt(1'b1, speed_clamped);
            end
            OP_SPIN_R: begin
                new_tgt[0] = mk_tgt(1'b1, speed_clamped);
                new_tgt[1] = mk_tgt(1'b0, speed_clamped);
            end
            OP_PIVOT_L: begin
                new_tgt[1] = mk_tgt(1'b1, speed_clamped);
            end
            OP_PIVOT_R: begin
                new_tgt[0] = mk_tgt(1'b1, speed_clamped);
            end
            default: begin
            end
        endcase
    end

    // Reversal is judged against the targets that will hold after this accept.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rev
            assign rev_new[gi] = cmd_load ? (new_tgt[gi].dir != dir_w[gi]) : rev_w[gi];
        end
    endgenerate

    assign rev_any_new = |rev_new;
    assign brake_done  = &(~rev_w | at_zero_w);
    assign dead_done   = tick && (dead_cnt_reg == DEAD_LAST);

    // Sequencer FSM with registered handshake and busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            dead_cnt_reg  <= '0;
        end else if (estop) begin
            state_reg     <= ST_IDLE;
            cmd_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
            dead_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_RAMP: begin
                    if (accept) begin
                        state_reg     <= rev_any_new ? ST_BRAKE : ST_RAMP;
                        cmd_ready_reg <= !rev_any_new;
                        busy_reg      <= 1'b1;
                    end else if (state_reg == ST_RAMP && (&at_tgt_w)) begin
                        state_reg     <= ST_IDLE;
                        cmd_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                    end else begin
                        cmd_ready_reg <= 1'b1;
                    end
                end
                ST_BRAKE: begin
                    if (brake_done) begin
                        state_reg    <= ST_DEAD;
                        dead_cnt_reg <= '0;
                    end
                end
                ST_DEAD: begin
                    if (dead_done) begin
                        state_reg     <= ST_RAMP;
                        cmd_ready_reg <= 1'b1;
                    end else if (tick) begin
                        dead_cnt_reg <= dead_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    cmd_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign step_en   = tick && (state_reg == ST_RAMP || state_reg == ST_BRAKE);
    assign brake     = (state_reg == ST_BRAKE);
    assign dir_apply = (state_reg == ST_DEAD) && dead_done;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            motor_ramp_channel #(
                .STEP     (STEP),
                .DUTY_MAX (DUTY_MAX)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .estop     (estop),
                .step_en   (step_en),
                .brake     (brake),
                .load      (cmd_load),
                .load_tgt  (new_tgt[gi]),
                .dir_apply (dir_apply),
                .duty      (duty_w[gi]),
                .dir       (dir_w[gi]),
                .reversing (rev_w[gi]),
                .at_target (at_tgt_w[gi]),
                .at_zero   (at_zero_w[gi])
            );
        end
    endgenerate

    assign duty_l    = duty_w[0];
    assign duty_r    = duty_w[1];
    assign dir_l     = dir_w[0];
    assign dir_r     = dir_w[1];
    assign cmd_ready = cmd_ready_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Self-checking bench for motor_drive_ctrl with a short ramp period and dead time.
module tb_motor_drive_ctrl;

    localparam int RD   = 4;
    localparam int STP  = 10;
    localparam int DMAX = 1000;
    localparam int DT   = 2;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [9:0] cmd_speed;
    logic       estop;
    logic [9:0] duty_l;
    logic [9:0] duty_r;
    logic       dir_l;
    logic       dir_r;
    logic       busy;

    motor_drive_ctrl #(
        .RAMP_DIV   (RD),
        .STEP       (STP),
        .DUTY_MAX   (DMAX),
        .DEAD_TICKS (DT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_speed (cmd_speed),
        .estop     (estop),
        .duty_l    (duty_l),
        .duty_r    (duty_r),
        .dir_l     (dir_l),
        .dir_r     (dir_r),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] dl;
        logic [9:0] dr;
        logic       dirl;
        logic       dirr;
    } obs_t;

    typedef struct {
        logic [2:0] op;
        logic [9:0] speed;
        int         exp_dl;
        int         exp_dr;
        int         exp_dirl;
        int         exp_dirr;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t seq_q[$];
    vec_t exp_q[$];
    logic mon_seq = 1'b0;
    obs_t prev_obs;
    logic est_d;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Change monitor: slew/limit properties on every output change, ordered scoreboard when enabled.
    always @(negedge clk) begin
        obs_t cur;
        obs_t e;
        int   dl;
        int   dr;
        int   pl;
        int   pr;
        cur = {duty_l, duty_r, dir_l, dir_r};
        if (rst) begin
            prev_obs <= cur;
            est_d    <= estop;
        end else begin
            if (cur != prev_obs) begin
                dl = cur.dl;
                dr = cur.dr;
                pl = prev_obs.dl;
                pr = prev_obs.dr;
                if (!est_d) begin
                    check_range("slew_l", dl - pl, -STP, STP);
                    check_range("slew_r", dr - pr, -STP, STP);
                end
                check_range("max_l", dl, 0, DMAX);
                check_range("max_r", dr, 0, DMAX);
                if (cur.dirl != prev_obs.dirl) check("flip_at_zero_l", dl, 0);
                if (cur.dirr != prev_obs.dirr) check("flip_at_zero_r", dr, 0);
                if (mon_seq) begin
                    n_checks++;
                    if (seq_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL seq: unexpected change to dl=%0d dr=%0d dirl=%0d dirr=%0d",
                                 cur.dl, cur.dr, cur.dirl, cur.dirr);
                    end else begin
                        e = seq_q.pop_front();
                        if (cur != e) begin
                            n_fail++;
                            $display("FAIL seq: got dl=%0d dr=%0d dirl=%0d dirr=%0d, expected dl=%0d dr=%0d dirl=%0d dirr=%0d",
                                     cur.dl, cur.dr, cur.dirl, cur.dirr, e.dl, e.dr, e.dirl, e.dirr);
                        end
                    end
                end
            end
            prev_obs <= cur;
            est_d    <= estop;
        end
    end

    // Present a command at a negedge and return at the negedge after it is accepted.
    task automatic send(input logic [2:0] op, input logic [9:0] spd);
        int guard;
        cmd_op    = op;
        cmd_speed = spd;
        cmd_valid = 1'b1;
        guard     = 0;
        while (!cmd_ready && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) timeout("accept");
        @(negedge clk);
        cmd_valid = 1'b0;
        $display("cmd op=%0d speed=%0d accepted", op, spd);
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        while (busy && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) timeout(name);
    endtask

    task automatic push_obs(input int dl, input int dr, input logic dirl, input logic dirr);
        obs_t o;
        o.dl   = 10'(dl);
        o.dr   = 10'(dr);
        o.dirl = dirl;
        o.dirr = dirr;
        seq_q.push_back(o);
    endtask

    vec_t tbl[8];

    initial begin
        int   guard;
        int   t0;
        int   t35;
        int   tbusy;
        int   ready_hi;
        int   gap;
        vec_t ev;

        tbl[0] = '{3'd0,  10'd0,    0,    0, 0, 1};
        tbl[1] = '{3'd1,  10'd40,   40,   40, 1, 1};
        tbl[2] = '{3'd5,  10'd500,  0,    500, 1, 1};
        tbl[3] = '{3'd6,  10'd60,   60,   0, 1, 1};
        tbl[4] = '{3'd7,  10'd999,  60,   0, 1, 1};
        tbl[5] = '{3'd4,  10'd30,   30,   30, 1, 0};
        tbl[6] = '{3'd2,  10'd1000, 1000, 1000, 0, 0};
        tbl[7] = '{3'd1,  10'd0,    0,    0, 1, 1};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_speed = 10'd0;
        estop     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state and quiet idle.
        check("rst_duty_l", duty_l, 0);
        check("rst_duty_r", duty_r, 0);
        check("rst_dir_l", dir_l, 1);
        check("rst_dir_r", dir_r, 1);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        mon_seq = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_duty_l", duty_l, 0);
        check("idle_duty_r", duty_r, 0);

        // FWD 35: 10,20,30,35 then busy drops one cycle after the final step.
        push_obs(10, 10, 1, 1);
        push_obs(20, 20, 1, 1);
        push_obs(30, 30, 1, 1);
        push_obs(35, 35, 1, 1);
        send(3'd1, 10'd35);
        check("fwd_busy_rise", busy, 1);
        guard = 0;
        t35   = -1;
        tbusy = -1;
        while (busy && guard < 200) begin
            if (duty_l == 10'd35 && t35 < 0) t35 = guard;
            @(negedge clk);
            guard++;
        end
        tbusy = guard;
        if (guard >= 200) timeout("fwd35_idle");
        check("fwd35_busy_fall", tbusy - t35, 1);
        check("fwd35_seq_drain", seq_q.size(), 0);

        // FWD 30 settled, then REV 20 through brake and dead time.
        push_obs(30, 30, 1, 1);
        send(3'd1, 10'd30);
        wait_idle("fwd30_idle");
        push_obs(20, 20, 1, 1);
        push_obs(10, 10, 1, 1);
        push_obs(0, 0, 1, 1);
        push_obs(0, 0, 0, 0);
        push_obs(10, 10, 0, 0);
        push_obs(20, 20, 0, 0);
        send(3'd2, 10'd20);
        guard    = 0;
        t0       = -1;
        ready_hi = 0;
        while (dir_l && guard < 300) begin
            if (cmd_ready) ready_hi++;
            if (duty_l == 10'd0 && t0 < 0) t0 = guard;
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) timeout("rev_flip");
        gap = guard - t0;
        check("rev_ready_low", ready_hi, 0);
        check_range("rev_dead_gap", gap, (DT - 1) * RD + 1, DT * RD + 1);
        wait_idle("rev_idle");
        check("rev_seq_drain", seq_q.size(), 0);

        // Reset pulse mid-DEAD, off the clock edge.
        mon_seq = 1'b0;
        send(3'd1, 10'd50);
        guard = 0;
        while (duty_l != 10'd0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) timeout("rstdead_zero");
        repeat (3) @(negedge clk);
        check("dead_dir_l", dir_l, 0);
        check("dead_ready", cmd_ready, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_duty_l", duty_l, 0);
        check("arst_duty_r", duty_r, 0);
        check("arst_dir_l", dir_l, 1);
        check("arst_dir_r", dir_r, 1);
        check("arst_ready", cmd_ready, 1);
        check("arst_busy", busy, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        mon_seq = 1'b1;
        push_obs(10, 10, 1, 1);
        send(3'd1, 10'd10);
        wait_idle("fwd10_idle");
        push_obs(0, 0, 1, 1);
        send(3'd0, 10'd0);
        wait_idle("stop_idle");
        check("fwd10_seq_drain", seq_q.size(), 0);

        // SPIN_L 1023 from rest: clamp to 1000, only the left motor reverses.
        mon_seq = 1'b0;
        send(3'd3, 10'd1023);
        wait_idle("spinl_idle");
        check("spinl_duty_l", duty_l, DMAX);
        check("spinl_duty_r", duty_r, DMAX);
        check("spinl_dir_l", dir_l, 0);
        check("spinl_dir_r", dir_r, 1);

        // Table of commands; expected settled outputs flow through a scoreboard queue.
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(tbl[i]);
            send(tbl[i].op, tbl[i].speed);
            wait_idle("tbl_idle");
            ev = exp_q.pop_front();
            check($sformatf("tbl%0d_duty_l", i), duty_l, ev.exp_dl);
            check($sformatf("tbl%0d_duty_r", i), duty_r, ev.exp_dr);
            check($sformatf("tbl%0d_dir_l", i), dir_l, ev.exp_dirl);
            check($sformatf("tbl%0d_dir_r", i), dir_r, ev.exp_dirr);
            $display("vec %0d: dl=%0d dr=%0d dirl=%0d dirr=%0d", i, duty_l, duty_r, dir_l, dir_r);
        end

        // Estop during a FWD ramp at duty 20.
        mon_seq = 1'b1;
        push_obs(10, 10, 1, 1);
        push_obs(20, 20, 1, 1);
        push_obs(0, 0, 1, 1);
        send(3'd1, 10'd100);
        guard = 0;
        while (duty_l != 10'd20 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) timeout("estop_reach20");
        estop = 1'b1;
        @(negedge clk);
        check("estop_duty_l", duty_l, 0);
        check("estop_duty_r", duty_r, 0);
        check("estop_ready", cmd_ready, 0);
        check("estop_dir_l", dir_l, 1);
        cmd_op    = 3'd1;
        cmd_speed = 10'd500;
        cmd_valid = 1'b1;
        ready_hi  = 0;
        repeat (6) begin
            @(negedge clk);
            if (cmd_ready) ready_hi++;
        end
        check("estop_ready_held", ready_hi, 0);
        estop     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("release_ready", cmd_ready, 1);
        repeat (10) @(negedge clk);
        check("release_busy", busy, 0);
        check("release_duty_l", duty_l, 0);
        check("estop_seq_drain", seq_q.size(), 0);
        $display("estop sequence done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
